// File: rtl/sdi_xcvr_csr_pkg.sv
// Shared definitions for the SDI transceiver CSR responder: register map,
// reset-release state encoding and the byte-lane mask helper.
package sdi_xcvr_csr_pkg;

  localparam int CSR_DATA_WIDTH = 32;

  localparam int CSR_ID     = 0;
  localparam int CSR_STATUS = 1;
  localparam int CSR_STICKY = 2;
  localparam int CSR_CTRL0  = 3;

  localparam logic [CSR_DATA_WIDTH-1:0] ID_VALUE_DEFAULT = 32'h5D1C_0001;
  localparam logic [CSR_DATA_WIDTH-1:0] UNMAPPED_VALUE   = 32'h0000_0000;

  // The slave holds off the master for one edge after reset, then stays ready.
  typedef enum logic {
    BUS_HOLD  = 1'b0,
    BUS_READY = 1'b1
  } bus_state_t;

  // Expands the 4-bit byteenable into a 32-bit bit mask.
  function automatic logic [CSR_DATA_WIDTH-1:0] lane_mask(input logic [3:0] be);
    logic [CSR_DATA_WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sdi_xcvr_rd_pipe.sv
// Fixed-latency read return pipeline. Data enters only alongside a valid,
// so the data output is zero whenever the valid output is low.
module sdi_xcvr_rd_pipe #(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]       vld_q;
  logic [LATENCY*WIDTH-1:0] data_q;
  logic [WIDTH-1:0]         in_masked;

  assign in_masked = in_valid ? in_data : '0;

  // Shift valid and data one stage per clock; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= (vld_q << 1) | LATENCY'(in_valid);
      data_q <= (data_q << WIDTH) | (LATENCY*WIDTH)'(in_masked);
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = data_q[LATENCY*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/sdi_xcvr_mm_csr_responder.sv
// Avalon-MM pipelined CSR slave for the SDI transceiver test bridge: ID word,
// live status, W1C sticky event flags and RW control words exported flat.
module sdi_xcvr_mm_csr_responder
  import sdi_xcvr_csr_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 4,
  parameter int          NUM_REGS     = 8,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] ID_VALUE     = ID_VALUE_DEFAULT,
  parameter int          EVT_WIDTH    = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [ADDR_WIDTH-1:0]                 s0_address,
  input  logic                                  s0_read,
  input  logic                                  s0_write,
  input  logic [DATA_WIDTH-1:0]                 s0_writedata,
  input  logic [3:0]                            s0_byteenable,
  input  logic                                  s0_burstcount,
  input  logic                                  s0_debugaccess,
  output logic                                  s0_waitrequest,
  output logic [DATA_WIDTH-1:0]                 s0_readdata,
  output logic                                  s0_readdatavalid,
  input  logic [DATA_WIDTH-1:0]                 status_in,
  input  logic [EVT_WIDTH-1:0]                  event_in,
  output logic [(NUM_REGS-3)*DATA_WIDTH-1:0]    ctrl_out
);

  localparam int NUM_CTRL = NUM_REGS - CSR_CTRL0;

  bus_state_t                   bus_state;
  logic [31:0]                  word_idx;
  logic                         wr_accept;
  logic                         rd_accept;
  logic [DATA_WIDTH-1:0]        wr_mask;
  logic [DATA_WIDTH-1:0]        rd_value;
  logic [EVT_WIDTH-1:0]         sticky_q;
  logic [EVT_WIDTH-1:0]         sticky_clr;
  logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_q;
  logic                         unused_inputs;

  // Single-beat only: burst count and debug access carry no meaning here.
  assign unused_inputs = ^{s0_burstcount, s0_debugaccess};

  assign word_idx       = 32'(s0_address);
  assign wr_mask        = lane_mask(s0_byteenable);
  assign s0_waitrequest = (bus_state == BUS_HOLD);

  // A write wins over a simultaneous read; the read is silently dropped.
  assign wr_accept = !s0_waitrequest && s0_write;
  assign rd_accept = !s0_waitrequest && s0_read && !s0_write;

  // Hold waitrequest through reset and the first edge after release, then stay ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_state <= BUS_HOLD;
    end else begin
      case (bus_state)
        BUS_HOLD:  bus_state <= BUS_READY;
        default:   bus_state <= BUS_READY;
      endcase
    end
  end

  // Decode the addressed word from the pre-edge register state.
  always_comb begin
    rd_value = UNMAPPED_VALUE;
    if (word_idx == CSR_ID) begin
      rd_value = ID_VALUE;
    end else if (word_idx == CSR_STATUS) begin
      rd_value = status_in;
    end else if (word_idx == CSR_STICKY) begin
      rd_value[EVT_WIDTH-1:0] = sticky_q;
    end else begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (word_idx == 32'(CSR_CTRL0 + k)) begin
          rd_value = ctrl_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign sticky_clr = (wr_accept && (word_idx == CSR_STICKY))
                    ? (s0_writedata[EVT_WIDTH-1:0] & wr_mask[EVT_WIDTH-1:0])
                    : '0;

  // Sticky flags: write-one-to-clear, with a same-edge event taking priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~sticky_clr) | event_in;
    end
  end

  // Control words merge only the byte lanes that are enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
    end else if (wr_accept) begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (word_idx == 32'(CSR_CTRL0 + k)) begin
          ctrl_q[k*DATA_WIDTH +: DATA_WIDTH] <=
            (ctrl_q[k*DATA_WIDTH +: DATA_WIDTH] & ~wr_mask) | (s0_writedata & wr_mask);
        end
      end
    end
  end

  assign ctrl_out = ctrl_q;

  sdi_xcvr_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (DATA_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rd_accept),
    .in_data   (rd_value),
    .out_valid (s0_readdatavalid),
    .out_data  (s0_readdata)
  );

endmodule

// File: tb/tb_sdi_xcvr_mm_csr_responder.sv
// Self-checking bench for the SDI transceiver CSR responder. A register-map
// model with a queue of pending read returns predicts every bus cycle.
`timescale 1ns/1ps

`define CHECK_BUS(NAME) begin \
  tests_run++; \
  if (s0_readdatavalid !== exp_rdv || s0_readdata !== exp_rdata) begin \
    tests_failed++; \
    $display("[TB] FAIL %s cycle %0d: got rdv=%0b data=%h, expected rdv=%0b data=%h", \
             NAME, cycle, s0_readdatavalid, s0_readdata, exp_rdv, exp_rdata); \
  end \
end

`define CHECK_CTRL(NAME) begin \
  tests_run++; \
  if (ctrl_out !== exp_ctrl()) begin \
    tests_failed++; \
    $display("[TB] FAIL %s cycle %0d: got ctrl_out=%h, expected %h", NAME, cycle, ctrl_out, exp_ctrl()); \
  end \
end

module tb_sdi_xcvr_mm_csr_responder;

  localparam int          DW   = 32;
  localparam int          AW   = 4;
  localparam int          NREG = 8;
  localparam int          LAT  = 2;
  localparam int          EW   = 8;
  localparam logic [31:0] IDV  = 32'h5D1C_0001;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [AW-1:0]           s0_address = '0;
  logic                    s0_read = 1'b0;
  logic                    s0_write = 1'b0;
  logic [DW-1:0]           s0_writedata = '0;
  logic [3:0]              s0_byteenable = '0;
  logic                    s0_burstcount = 1'b1;
  logic                    s0_debugaccess = 1'b0;
  logic                    s0_waitrequest;
  logic [DW-1:0]           s0_readdata;
  logic                    s0_readdatavalid;
  logic [DW-1:0]           status_in = '0;
  logic [EW-1:0]           event_in = '0;
  logic [(NREG-3)*DW-1:0]  ctrl_out;

  always #5 clk = ~clk;

  sdi_xcvr_mm_csr_responder #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .NUM_REGS     (NREG),
    .READ_LATENCY (LAT),
    .ID_VALUE     (IDV),
    .EVT_WIDTH    (EW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s0_address       (s0_address),
    .s0_read          (s0_read),
    .s0_write         (s0_write),
    .s0_writedata     (s0_writedata),
    .s0_byteenable    (s0_byteenable),
    .s0_burstcount    (s0_burstcount),
    .s0_debugaccess   (s0_debugaccess),
    .s0_waitrequest   (s0_waitrequest),
    .s0_readdata      (s0_readdata),
    .s0_readdatavalid (s0_readdatavalid),
    .status_in        (status_in),
    .event_in         (event_in),
    .ctrl_out         (ctrl_out)
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cycle = 0;

  // Reference model state
  logic [31:0] reg_m [NREG];
  logic [EW-1:0] sticky_m;
  bit          hold_m;
  int          due_q [$];
  logic [31:0] data_q [$];
  logic        exp_rdv;
  logic [31:0] exp_rdata;

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return IDV;
    if (a == 1) return status_in;
    if (a == 2) return 32'(sticky_m);
    if (a >= 3 && a < NREG) return reg_m[a];
    return 32'h0;
  endfunction

  function automatic logic [(NREG-3)*DW-1:0] exp_ctrl();
    logic [(NREG-3)*DW-1:0] r;
    r = '0;
    for (int k = 3; k < NREG; k++) r[(k-3)*DW +: DW] = reg_m[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) reg_m[k] = 32'h0;
    sticky_m  = '0;
    hold_m    = 1'b1;
    due_q.delete();
    data_q.delete();
    exp_rdv   = 1'b0;
    exp_rdata = 32'h0;
  endtask

  task automatic set_cmd(input bit rd, input bit wr, input int addr,
                         input logic [31:0] wd, input logic [3:0] be);
    s0_read       = rd;
    s0_write      = wr;
    s0_address    = AW'(addr);
    s0_writedata  = wd;
    s0_byteenable = be;
  endtask

  // Advance one clock edge, applying the register-map rules to the model and
  // producing the expected bus outputs for the following cycle.
  task automatic step();
    bit            acc;
    int            a;
    logic [31:0]   rv;
    logic [EW-1:0] clr;
    logic [EW-1:0] ev;
    bit            in_reset;
    a        = int'(s0_address);
    in_reset = !reset_n;
    acc      = !in_reset && !hold_m && (s0_read || s0_write);
    rv       = model_read(a);
    ev       = event_in;
    clr      = '0;
    if (acc && s0_write) begin
      for (int b = 0; b < 4; b++) begin
        if (s0_byteenable[b]) begin
          if (a >= 3 && a < NREG) reg_m[a][8*b +: 8] = s0_writedata[8*b +: 8];
          for (int i = 0; i < EW; i++)
            if (a == 2 && (i / 8) == b && s0_writedata[i]) clr[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    cycle++;
    if (!in_reset) begin
      sticky_m = (sticky_m & ~clr) | ev;
      hold_m   = 1'b0;
      if (acc && s0_read && !s0_write) begin
        due_q.push_back(cycle + LAT - 1);
        data_q.push_back(rv);
      end
    end
    #1;
    exp_rdv   = 1'b0;
    exp_rdata = 32'h0;
    if (due_q.size() > 0 && due_q[0] == cycle) begin
      exp_rdv   = 1'b1;
      exp_rdata = data_q.pop_front();
      void'(due_q.pop_front());
    end
  endtask

  // Issue one read and wait for its return, checking the bus every cycle.
  task automatic do_read(input int addr, input string name, output logic [31:0] got);
    got = 32'hDEAD_BEEF;
    set_cmd(1, 0, addr, 32'h0, 4'h0);
    step();
    `CHECK_BUS(name)
    if (s0_readdatavalid) got = s0_readdata;
    set_cmd(0, 0, 0, 32'h0, 4'h0);
    for (int c = 0; c < LAT; c++) begin
      step();
      `CHECK_BUS(name)
      if (s0_readdatavalid) got = s0_readdata;
    end
  endtask

  task automatic test_reset();
    int nid;
    reset_n = 1'b0;
    set_cmd(0, 0, 0, 32'h0, 4'h0);
    #1;
    model_reset();
    tests_run++;
    if (s0_waitrequest !== 1'b1 || s0_readdatavalid !== 1'b0 || s0_readdata !== 32'h0 || ctrl_out !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got wr=%0b rdv=%0b data=%h ctrl=%h, expected 1 0 0 0",
               s0_waitrequest, s0_readdatavalid, s0_readdata, ctrl_out);
    end
    step(); step();
    `CHECK_BUS("reset_hold")
    reset_n = 1'b1;
    set_cmd(1, 0, 0, 32'h0, 4'h0);
    #1;
    tests_run++;
    if (s0_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL release_wait_before_edge: got %0b, expected 1", s0_waitrequest);
    end
    step();
    tests_run++;
    if (s0_waitrequest !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL release_wait_after_edge: got %0b, expected 0", s0_waitrequest);
    end
    `CHECK_BUS("release_first_edge")
    nid = 0;
    step();
    `CHECK_BUS("id_read_accept")
    set_cmd(0, 0, 0, 32'h0, 4'h0);
    for (int c = 0; c < LAT + 1; c++) begin
      step();
      `CHECK_BUS("id_read_return")
      if (s0_readdatavalid && s0_readdata === 32'h5D1C_0001) nid++;
    end
    tests_run++;
    if (nid != 1) begin
      tests_failed++;
      $display("[TB] FAIL id_read_count: got %0d ID returns, expected 1", nid);
    end
  endtask

  task automatic test_byteenable_write();
    logic [31:0] got;
    set_cmd(0, 1, 3, 32'h0, 4'hF);          step(); `CHECK_BUS("be_clear")
    set_cmd(0, 1, 3, 32'hAABBCCDD, 4'b0101); step(); `CHECK_BUS("be_partial")
    set_cmd(0, 1, 3, 32'hFFFFFFFF, 4'b0000); step(); `CHECK_BUS("be_none")
    set_cmd(0, 1, 0, 32'h12345678, 4'hF);   step(); `CHECK_BUS("ro_write")
    set_cmd(0, 0, 0, 32'h0, 4'h0);          step();
    `CHECK_CTRL("be_ctrl_out")
    tests_run++;
    if (ctrl_out[31:0] !== 32'h00BB00DD) begin
      tests_failed++;
      $display("[TB] FAIL be_word3: got %h, expected 00bb00dd", ctrl_out[31:0]);
    end
    do_read(3, "be_readback", got);
    tests_run++;
    if (got !== 32'h00BB00DD) begin
      tests_failed++;
      $display("[TB] FAIL be_readback_value: got %h, expected 00bb00dd", got);
    end
    do_read(0, "ro_readback", got);
    tests_run++;
    if (got !== IDV) begin
      tests_failed++;
      $display("[TB] FAIL ro_write_ignored: got %h, expected %h", got, IDV);
    end
  endtask

  task automatic test_sticky();
    logic [31:0] got;
    event_in = 8'h05; step(); event_in = 8'h00;
    do_read(2, "sticky_set", got);
    tests_run++;
    if (got !== 32'h05) begin
      tests_failed++;
      $display("[TB] FAIL sticky_set_value: got %h, expected 00000005", got);
    end
    set_cmd(0, 1, 2, 32'h01, 4'hF); event_in = 8'h01; step();
    `CHECK_BUS("sticky_set_wins_cycle")
    event_in = 8'h00;
    do_read(2, "sticky_set_wins", got);
    tests_run++;
    if (got !== 32'h05) begin
      tests_failed++;
      $display("[TB] FAIL sticky_set_wins_value: got %h, expected 00000005", got);
    end
    set_cmd(0, 1, 2, 32'h04, 4'hF); step();
    do_read(2, "sticky_w1c", got);
    tests_run++;
    if (got !== 32'h01) begin
      tests_failed++;
      $display("[TB] FAIL sticky_w1c_value: got %h, expected 00000001", got);
    end
  endtask

  task automatic test_back_to_back();
    int          addrs [4];
    logic [31:0] want [4];
    logic [31:0] seen [$];
    addrs = '{0, 1, 3, 15};
    status_in = 32'h1234;
    want = '{IDV, 32'h1234, reg_m[3], 32'h0};
    for (int i = 0; i < 4; i++) begin
      set_cmd(1, 0, addrs[i], 32'h0, 4'h0);
      step();
      `CHECK_BUS("b2b_issue")
      if (s0_readdatavalid) seen.push_back(s0_readdata);
    end
    set_cmd(0, 0, 0, 32'h0, 4'h0);
    for (int c = 0; c < LAT + 1; c++) begin
      step();
      `CHECK_BUS("b2b_drain")
      if (s0_readdatavalid) seen.push_back(s0_readdata);
    end
    tests_run++;
    if (seen.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: got %0d valids, expected 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (seen[i] !== want[i]) begin
          tests_failed++;
          $display("[TB] FAIL b2b_data[%0d]: got %h, expected %h", i, seen[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_write_then_read();
    logic [31:0] got;
    set_cmd(0, 1, 4, 32'h11, 4'hF); step(); `CHECK_BUS("wr4")
    do_read(4, "rd4_after_wr", got);
    tests_run++;
    if (got !== 32'h11) begin
      tests_failed++;
      $display("[TB] FAIL write_then_read: got %h, expected 00000011", got);
    end
    set_cmd(1, 1, 5, 32'h5A5A, 4'hF); step(); `CHECK_BUS("rdwr_same")
    set_cmd(0, 0, 0, 32'h0, 4'h0);
    for (int c = 0; c < LAT + 1; c++) begin
      step();
      `CHECK_BUS("rdwr_no_valid")
    end
    `CHECK_CTRL("rdwr_ctrl_out")
    tests_run++;
    if (ctrl_out[2*DW +: DW] !== 32'h5A5A) begin
      tests_failed++;
      $display("[TB] FAIL rdwr_write_lands: got %h, expected 00005a5a", ctrl_out[2*DW +: DW]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_cmd($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              int'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      status_in = $urandom;
      event_in  = ($urandom_range(0, 3) == 0) ? EW'($urandom) : '0;
      step();
      `CHECK_BUS("random_bus")
      `CHECK_CTRL("random_ctrl")
      tests_run++;
      if (s0_waitrequest !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL random_waitrequest: got %0b, expected 0", s0_waitrequest);
      end
    end
    set_cmd(0, 0, 0, 32'h0, 4'h0);
    event_in = '0;
    for (int c = 0; c < LAT + 1; c++) begin
      step();
      `CHECK_BUS("random_drain")
    end
  endtask

  task automatic test_reset_mid_read();
    int nvalid;
    set_cmd(0, 1, 6, 32'hCAFE_F00D, 4'hF); step();
    set_cmd(1, 0, 6, 32'h0, 4'h0); step();
    set_cmd(0, 0, 0, 32'h0, 4'h0);
    reset_n = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (s0_waitrequest !== 1'b1 || s0_readdatavalid !== 1'b0 || s0_readdata !== 32'h0 || ctrl_out !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midread_reset_values: got wr=%0b rdv=%0b data=%h ctrl=%h, expected 1 0 0 0",
               s0_waitrequest, s0_readdatavalid, s0_readdata, ctrl_out);
    end
    nvalid = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      `CHECK_BUS("midread_in_reset")
      if (s0_readdatavalid) nvalid++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      step();
      `CHECK_BUS("midread_after_release")
      if (s0_readdatavalid) nvalid++;
    end
    tests_run++;
    if (nvalid != 0) begin
      tests_failed++;
      $display("[TB] FAIL midread_no_valid: got %0d valids, expected 0", nvalid);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_byteenable_write();
    test_sticky();
    test_back_to_back();
    test_write_then_read();
    test_random();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sdi_xcvr_mm_csr_responder.md
Name: sdi_xcvr_mm_csr_responder

Overview:
- Avalon-MM pipelined slave (responder) terminating the m0 master side of the transceiver-test MM bridge.
- Owns a small CSR bank: ID, live status, sticky event flags (W1C), and RW control words exported to the SDI transceiver logic.
- Fixed-latency reads with readdatavalid, byteenable-qualified writes, waitrequest only around reset release.

Parameters:
- DATA_WIDTH, 32, data bus width; must be 32.
- ADDR_WIDTH, 4, word-address width of s0_address.
- NUM_REGS, 8, implemented words; addresses 0..NUM_REGS-1; range 4..2**ADDR_WIDTH.
- READ_LATENCY, 2, cycles from read accept to readdatavalid; range 1..4.
- ID_VALUE, 32'h5D1C_0001, constant returned at word 0.
- EVT_WIDTH, 8, number of sticky event inputs; range 1..32.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- s0_address  in  ADDR_WIDTH  word address
- s0_read  in  1  read request
- s0_write  in  1  write request
- s0_writedata  in  DATA_WIDTH  write data
- s0_byteenable  in  4  byte lanes for writes
- s0_burstcount  in  1  ignored (single-beat only)
- s0_debugaccess  in  1  ignored
- s0_waitrequest  out  1  stall
- s0_readdata  out  DATA_WIDTH  read data
- s0_readdatavalid  out  1  read data valid
- status_in  in  DATA_WIDTH  live status, shown at word 1
- event_in  in  EVT_WIDTH  single-cycle event pulses
- ctrl_out  out  (NUM_REGS-3)*DATA_WIDTH  control words 3..NUM_REGS-1, flat; word 3 at LSBs

Behaviour:
- Reset (reset_n low, async):
  - s0_waitrequest=1, s0_readdatavalid=0, s0_readdata=0.
  - Sticky and control registers cleared; read pipeline flushed.
- Reset release: s0_waitrequest stays 1 for exactly one clk edge after reset_n rises, then 0 permanently.
- Accept: a command is accepted on a clk edge where waitrequest=0 and read or write is high.
- Read and write both high: the write is performed; the read is dropped, with no readdatavalid.
- Register map:
  - word 0: ID_VALUE, RO.
  - word 1: status_in sampled at the accept edge, RO.
  - word 2: sticky. Bit i sets when event_in[i]=1 on an edge. Writing 1 to bit i (byte-enabled) clears it. If set and clear occur on the same edge, set wins. Bits >= EVT_WIDTH read 0.
  - words 3..NUM_REGS-1: RW, byteenable per byte lane, drive ctrl_out.
- Writes:
  - Registers update on the accept edge; ctrl_out reflects new values from the next cycle.
  - byteenable=0 means no change.
  - Writes to RO or unmapped words are ignored.
- Reads:
  - Data is captured at the accept edge. The captured value excludes a write accepted on that same edge; a read accepted on the next edge sees the new value.
  - Unmapped words read 32'h0.
  - Data travels down a READ_LATENCY-deep valid/data shift pipeline.
  - s0_readdatavalid pulses for 1 cycle exactly READ_LATENCY edges after accept, with s0_readdata valid. Back-to-back reads give back-to-back valids in order.
  - s0_readdata is 0 whenever readdatavalid=0.
- Pipeline: no backpressure is needed (fixed latency, no outstanding limit). waitrequest never asserts for traffic.
- Reset mid-read: in-flight reads are discarded; no readdatavalid after reset.

Decomposition:
- Shared package sdi_xcvr_csr_pkg: register index constants (CSR_ID=0, CSR_STATUS=1, CSR_STICKY=2, CSR_CTRL0=3), ID_VALUE default, unmapped read value.
- One sub-module, sdi_xcvr_rd_pipe: parameterised READ_LATENCY valid/data shift pipeline with async active-low clear.
- Top contains decode, byteenable write logic, sticky logic, and the waitrequest release flop.

Test Plan:
- Reset then release -> waitrequest 1 until one edge after reset_n rise; read word 0 -> readdatavalid 2 cycles later with 32'h5D1C0001.
- Write word 3 = 32'hAABBCCDD with be=4'b0101 after writing 0 -> ctrl_out[31:0]=32'h00BB00DD; read-back matches.
- event_in=8'h05 pulse; read word 2 -> 32'h05. Write 32'h01 to word 2 while event_in[0] pulses on the same edge -> reads 32'h05. Then write 32'h04 -> reads 32'h01.
- Four back-to-back reads of words 0,1,3,15 (status_in=32'h1234) -> four consecutive valids carrying ID, 32'h1234, ctrl value, 32'h0.
- Write word 4 = 32'h11 followed next edge by read word 4 -> returns 32'h11. Read and write asserted together -> write lands, no readdatavalid.
- Read accepted, then reset_n asserted 1 cycle later -> no readdatavalid; all outputs at reset values.
